execute_unit: RTL and testbench
===============================

# execute_unit

Execute-stage consumer of the decode/execute pipeline register in the 16-bit pipelined CPU. Latches one decoded operation (ALU opcode, two 16-bit operands, writeback/memory control sideband) per valid/ready handshake. Single-cycle ops complete in one cycle; MUL runs as an iterative shift-add. The registered result, flags and sideband are presented to the execute/memory register, with backpressure toward decode.

## Interface
- No parameters; data width is fixed at 16.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  synchronous kill of in-flight op and pending output.
- `in_valid`  in  1  decode/execute register holds an op.
- `in_ready`  out  1  op accepted on edge where `in_valid & in_ready`.
- `ALUop_in`  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- `srcA_in`, `srcB_in`  in  16 each  operands; shifts use `srcB_in[3:0]`.
- `ni_in`  in  1  null instruction (bubble); no arithmetic performed.
- `wbs_in`, `wme_in`, `wm_in`, `am_in`  in  1 each; `mm_in`  in  2  sideband, carried unchanged.
- `out_valid`  out  1  result registers hold a completed op.
- `out_ready`  in  1  downstream consumes on edge where `out_valid & out_ready`.
- `result_out`  out  16  ALU result.
- `zero_out`, `neg_out`, `carry_out`, `err_out`  out  1 each  flags.
- `wbs_out`, `wme_out`, `wm_out`, `am_out`  out  1 each; `mm_out`  out  2  latched sideband.
- `busy_out`  out  1  high while in MUL state.

## Operation
- States: IDLE, MUL. Reset/flush -> IDLE.
- `in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush`.
- Accept in IDLE, non-MUL or `ni_in=1`: result, flags and sideband loaded into output registers on the accepting edge; `out_valid` set.
- Accept with `ALUop_in=111`, `ni_in=0`: operands and sideband latched, 4-bit counter cleared, -> MUL. Each edge adds `multiplicand<<cnt` when `multiplier[cnt]` is set. On the edge with cnt==15, output registers load the low 16 bits of the product, `out_valid` is set, and the state -> IDLE.
- `ni_in=1`: result 0, all flags 0, sideband passed through.
- Arithmetic is modulo 2^16. ADD: `carry` = bit 16 of the sum. SUB: `carry` = borrow (`srcA<srcB` unsigned). SHL/SHR shift by 0–15, vacated bits are 0. All other ops: `carry`=0.
- `zero` = (result==0). `neg` = result[15]. `err`=0 except as noted under Configuration.
- Output holds stable while `out_valid & !out_ready`. `out_valid` clears on consume unless a new op loads on the same edge.
- Priority: `rst` > `flush` > handshake. Flush clears `out_valid` and abandons MUL; no partial result is emitted.

## Timing
- Reset values: `out_valid`=0, `in_ready`=0 during reset cycle (1 after), `busy_out`=0, `result_out`=0, all flags 0, all sideband outputs 0, state IDLE.
- Single-cycle op accepted at edge N: `out_valid` visible after edge N. Throughput is 1/cycle with `out_ready` held high.
- MUL accepted at edge N: `busy_out` high after N through edge N+16. Result is valid after edge N+16 (latency 16). `in_ready` is low throughout.
- Back-to-back: an op may be accepted on the same edge the previous result is consumed.
- Flush and `in_valid` in the same cycle: the op is not accepted.

## Configuration
- `EXEC_MUL_EN` defined: iterative MUL datapath and MUL state present as above.
- Undefined: no multiplier logic. `ALUop_in=111` completes as a single-cycle op with result 0, `zero`=1, and `err_out`=1. `busy_out` is tied 0.

## Test plan
- Reset, then ADD 0xFFFF+0x0001, `out_ready`=1 -> next cycle result 0x0000, zero=1, carry=1, neg=0.
- SUB 0x0003−0x0005 -> result 0xFFFE, carry=1, neg=1. SHL 0x0001 by srcB=0x0013 -> 0x0008.
- MUL 0x0123×0x0010 (`EXEC_MUL_EN`) -> `in_ready` low for 16 cycles, then result 0x1230 exactly 16 edges after accept. Without the macro: result 0, err=1, 1 cycle.
- Hold `out_ready`=0 with an ADD pending -> outputs stable, `in_ready`=0. Release -> consumed, and the next op is accepted on the same edge.
- Flush at MUL cycle 8 -> `busy_out` and `out_valid` 0 next cycle, no result emitted. A new ADD accepted afterwards completes normally.
- `ni_in`=1 with `ALUop_in`=111, `wbs_in`=1, `mm_in`=2 -> 1-cycle completion, result 0, flags 0, `wbs_out`=1, `mm_out`=2.

Source files
------------

// File: rtl/execute_unit_if.sv
// Handshake and data bundle between the decode/execute register, the execute unit
// and the execute/memory register. master = upstream/downstream driver, slave = execute_unit.
interface execute_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUop_in;
  logic [15:0] srcA_in;
  logic [15:0] srcB_in;
  logic        ni_in;
  logic        wbs_in;
  logic        wme_in;
  logic        wm_in;
  logic        am_in;
  logic [1:0]  mm_in;

  logic        out_valid;
  logic        out_ready;
  logic [15:0] result_out;
  logic        zero_out;
  logic        neg_out;
  logic        carry_out;
  logic        err_out;
  logic        wbs_out;
  logic        wme_out;
  logic        wm_out;
  logic        am_out;
  logic [1:0]  mm_out;
  logic        busy_out;

  modport master (
    output in_valid, ALUop_in, srcA_in, srcB_in, ni_in,
           wbs_in, wme_in, wm_in, am_in, mm_in, out_ready,
    input  in_ready, out_valid, result_out, zero_out, neg_out, carry_out, err_out,
           wbs_out, wme_out, wm_out, am_out, mm_out, busy_out
  );

  modport slave (
    input  in_valid, ALUop_in, srcA_in, srcB_in, ni_in,
           wbs_in, wme_in, wm_in, am_in, mm_in, out_ready,
    output in_ready, out_valid, result_out, zero_out, neg_out, carry_out, err_out,
           wbs_out, wme_out, wm_out, am_out, mm_out, busy_out
  );
endinterface

// File: rtl/execute_unit.sv
// Execute stage of the 16-bit pipelined CPU: single-cycle ALU plus optional iterative MUL.
// Define EXEC_MUL_EN to build the shift-add multiplier; otherwise MUL reports err_out.
module execute_unit (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  execute_unit_if.slave io
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;

  typedef struct packed {
    logic       wbs;
    logic       wme;
    logic       wm;
    logic       am;
    logic [1:0] mm;
  } sideband_t;

  typedef struct packed {
    logic [15:0] result;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        err;
  } alu_out_t;

  state_e    state_q, state_d;
  logic      out_valid_q, out_valid_d;
  alu_out_t  res_q, res_d;
  sideband_t sb_q, sb_d;

  sideband_t   sb_in;
  alu_out_t    alu;
  logic [16:0] add_w;
  logic [16:0] sub_w;
  logic        accept;
  logic        is_mul;

  assign sb_in  = {io.wbs_in, io.wme_in, io.wm_in, io.am_in, io.mm_in};
  assign io.in_ready = (state_q == S_IDLE) & (!out_valid_q | io.out_ready) & !flush & !rst;
  assign accept = io.in_valid & io.in_ready;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    alu   = '0;
    add_w = {1'b0, io.srcA_in} + {1'b0, io.srcB_in};
    // Bit 16 of the 17-bit difference is the unsigned borrow.
    sub_w = {1'b0, io.srcA_in} - {1'b0, io.srcB_in};
    case (io.ALUop_in)
      OP_ADD: begin
        alu.result = add_w[15:0];
        alu.carry  = add_w[16];
      end
      OP_SUB: begin
        alu.result = sub_w[15:0];
        alu.carry  = sub_w[16];
      end
      OP_AND: alu.result = io.srcA_in & io.srcB_in;
      OP_OR:  alu.result = io.srcA_in | io.srcB_in;
      OP_XOR: alu.result = io.srcA_in ^ io.srcB_in;
      OP_SHL: alu.result = io.srcA_in << io.srcB_in[3:0];
      OP_SHR: alu.result = io.srcA_in >> io.srcB_in[3:0];
      default: begin
        alu.result = '0;
`ifndef EXEC_MUL_EN
        alu.err    = 1'b1;
`endif
      end
    endcase
    alu.zero = (alu.result == 16'h0000);
    alu.neg  = alu.result[15];
    // A bubble carries its sideband but reports nothing, not even zero.
    if (io.ni_in) begin
      alu = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Iterative shift-add multiplier
  // ---------------------------------------------------------------------------
`ifdef EXEC_MUL_EN
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] acc_next;
  logic [3:0]  cnt_q, cnt_d;
  sideband_t   sb_pend_q, sb_pend_d;

  assign is_mul   = (io.ALUop_in == OP_MUL) & !io.ni_in;
  assign acc_next = acc_q + (mplier_q[cnt_q] ? (mcand_q << cnt_q) : 16'h0000);
  assign io.busy_out = (state_q == S_MUL);
`else
  assign is_mul      = 1'b0;
  assign io.busy_out = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q & !io.out_ready;
    res_d       = res_q;
    sb_d        = sb_q;
`ifdef EXEC_MUL_EN
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sb_pend_d   = sb_pend_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
`ifdef EXEC_MUL_EN
            state_d   = S_MUL;
            mcand_d   = io.srcA_in;
            mplier_d  = io.srcB_in;
            acc_d     = '0;
            cnt_d     = '0;
            sb_pend_d = sb_in;
`endif
          end else begin
            res_d       = alu;
            sb_d        = sb_in;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
`ifdef EXEC_MUL_EN
        acc_d = acc_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'hF) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          res_d       = '{result: acc_next, zero: (acc_next == 16'h0000),
                          neg: acc_next[15], carry: 1'b0, err: 1'b0};
          sb_d        = sb_pend_q;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Flush abandons any multiply and drops a pending result.
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      sb_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      sb_q        <= sb_d;
    end
  end

`ifdef EXEC_MUL_EN
  // NOTE: multiplier datapath registers are not reset; they are always loaded on accept
  // before being read, and the state register alone decides whether they matter.
  always_ff @(posedge clk) begin
    mcand_q   <= mcand_d;
    mplier_q  <= mplier_d;
    acc_q     <= acc_d;
    cnt_q     <= cnt_d;
    sb_pend_q <= sb_pend_d;
  end
`endif

  assign io.out_valid  = out_valid_q;
  assign io.result_out = res_q.result;
  assign io.zero_out   = res_q.zero;
  assign io.neg_out    = res_q.neg;
  assign io.carry_out  = res_q.carry;
  assign io.err_out    = res_q.err;
  assign io.wbs_out    = sb_q.wbs;
  assign io.wme_out    = sb_q.wme;
  assign io.wm_out     = sb_q.wm;
  assign io.am_out     = sb_q.am;
  assign io.mm_out     = sb_q.mm;

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: vector table for single-cycle ops plus hand-written
// sequences for MUL latency, backpressure and flush. Follows EXEC_MUL_EN like the RTL.
module tb_execute_unit;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SHL = 3'b101;
  localparam logic [2:0] SHR = 3'b110;
  localparam logic [2:0] MUL = 3'b111;

  // sb = {wbs, wme, wm, am, mm[1:0]}, flags = {zero, neg, carry, err}
  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ni;
    logic [5:0]  sb;
    logic [15:0] res;
    logic [3:0]  flags;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[14];

  execute_unit_if bus ();

  execute_unit dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic ni, input logic [5:0] sb);
    bus.ALUop_in = op;
    bus.srcA_in  = a;
    bus.srcB_in  = b;
    bus.ni_in    = ni;
    {bus.wbs_in, bus.wme_in, bus.wm_in, bus.am_in, bus.mm_in} = sb;
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.zero_out, bus.neg_out, bus.carry_out, bus.err_out};
  endfunction

  function automatic logic [5:0] sb_now();
    return {bus.wbs_out, bus.wme_out, bus.wm_out, bus.am_out, bus.mm_out};
  endfunction

  task automatic check_out(input string name, input logic [15:0] res, input logic [3:0] flags,
                           input logic [5:0] sb);
    check({name, ".valid"},  {31'd0, bus.out_valid}, 32'd1);
    check({name, ".result"}, {16'd0, bus.result_out}, {16'd0, res});
    check({name, ".flags"},  {28'd0, flags_now()}, {28'd0, flags});
    check({name, ".sb"},     {26'd0, sb_now()}, {26'd0, sb});
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("drain.valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic do_mul(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input logic [3:0] exp_flags,
                        input logic [5:0] sb);
    drive(MUL, a, b, 1'b0, sb);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check({name, ".in_ready_pre"}, {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
`ifdef EXEC_MUL_EN
    for (int k = 1; k < 16; k++) begin
      check({name, ".busy"},     {31'd0, bus.busy_out}, 32'd1);
      check({name, ".in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      check({name, ".no_valid"}, {31'd0, bus.out_valid}, 32'd0);
      tick();
    end
    check({name, ".busy_last"}, {31'd0, bus.busy_out}, 32'd1);
    tick();
    check_out(name, exp_res, exp_flags, sb);
    check({name, ".busy_done"}, {31'd0, bus.busy_out}, 32'd0);
`else
    check_out(name, 16'h0000, 4'b1001, sb);
    check({name, ".busy"}, {31'd0, bus.busy_out}, 32'd0);
    if (exp_res == 16'hFFFF && exp_flags == 4'hF) $display("unused");
`endif
  endtask

  initial begin
    //          op   a        b        ni    sb         res      z n c e
    vecs[0]  = '{ADD, 16'hFFFF, 16'h0001, 1'b0, 6'b000000, 16'h0000, 4'b1010};
    vecs[1]  = '{SUB, 16'h0003, 16'h0005, 1'b0, 6'b100001, 16'hFFFE, 4'b0110};
    vecs[2]  = '{SHL, 16'h0001, 16'h0013, 1'b0, 6'b010010, 16'h0008, 4'b0000};
    vecs[3]  = '{AND, 16'hF0F0, 16'h3C3C, 1'b0, 6'b001011, 16'h3030, 4'b0000};
    vecs[4]  = '{OR,  16'hF000, 16'h000F, 1'b0, 6'b000100, 16'hF00F, 4'b0100};
    vecs[5]  = '{XOR, 16'hAAAA, 16'hAAAA, 1'b0, 6'b111111, 16'h0000, 4'b1000};
    vecs[6]  = '{SHR, 16'h8000, 16'h000F, 1'b0, 6'b000000, 16'h0001, 4'b0000};
    vecs[7]  = '{ADD, 16'h7FFF, 16'h0001, 1'b0, 6'b000001, 16'h8000, 4'b0100};
    vecs[8]  = '{SUB, 16'h0005, 16'h0005, 1'b0, 6'b000000, 16'h0000, 4'b1000};
    vecs[9]  = '{MUL, 16'h1234, 16'h5678, 1'b1, 6'b100010, 16'h0000, 4'b0000};
    vecs[10] = '{SHL, 16'hFFFF, 16'h0010, 1'b0, 6'b000000, 16'hFFFF, 4'b0100};
    vecs[11] = '{SUB, 16'h0000, 16'hFFFF, 1'b0, 6'b010101, 16'h0001, 4'b0010};
    vecs[12] = '{SHR, 16'hFFFF, 16'h0004, 1'b0, 6'b000000, 16'h0FFF, 4'b0000};
    vecs[13] = '{ADD, 16'h8000, 16'h8000, 1'b1, 6'b000000, 16'h0000, 4'b0000};

    // Reset
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(ADD, 16'h0000, 16'h0000, 1'b0, 6'b000000);
    tick();
    tick();
    check("rst.valid",    {31'd0, bus.out_valid}, 32'd0);
    check("rst.in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst.busy",     {31'd0, bus.busy_out}, 32'd0);
    check("rst.result",   {16'd0, bus.result_out}, 32'd0);
    check("rst.flags",    {28'd0, flags_now()}, 32'd0);
    check("rst.sb",       {26'd0, sb_now()}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst.in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Single-cycle vectors, back-to-back with out_ready held high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ni, vecs[i].sb);
      #1;
      check($sformatf("vec%0d.in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].flags, vecs[i].sb);
    end
    drain();

    // Multiply: latency, overflow wrap, multiplier bit 0 and bit 15, zero product
    do_mul("mul_a", 16'h0123, 16'h0010, 16'h1230, 4'b0000, 6'b101000);
    drain();
    do_mul("mul_b", 16'h0003, 16'h8001, 16'h8003, 4'b0100, 6'b000011);
    drain();
    do_mul("mul_c", 16'hFFFF, 16'h0000, 16'h0000, 4'b1000, 6'b010000);
    drain();

    // Backpressure: result held, new op accepted on the consuming edge
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(ADD, 16'h1111, 16'h2222, 1'b0, 6'b000011);
    tick();
    check_out("bp.first", 16'h3333, 4'b0000, 6'b000011);
    drive(ADD, 16'h0001, 16'h0001, 1'b0, 6'b100000);
    #1;
    check("bp.in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check_out("bp.hold", 16'h3333, 4'b0000, 6'b000011);
      check("bp.hold.in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp.release.in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    check_out("bp.second", 16'h0002, 4'b0000, 6'b100000);
    drain();

    // Flush with in_valid: op not accepted
    drive(ADD, 16'h0004, 16'h0004, 1'b0, 6'b000000);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_in.in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("flush_in.valid", {31'd0, bus.out_valid}, 32'd0);
    flush = 1'b0;

    // Flush drops a pending, unconsumed result
    bus.out_ready = 1'b0;
    tick();
    check_out("flush_pend.loaded", 16'h0008, 4'b0000, 6'b000000);
    bus.in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_pend.valid", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;

`ifdef EXEC_MUL_EN
    // Flush during MUL cycle 8: no partial or late result
    drive(MUL, 16'h0123, 16'h0010, 1'b0, 6'b111111);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("flush_mul.busy_before", {31'd0, bus.busy_out}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_mul.busy", {31'd0, bus.busy_out}, 32'd0);
    check("flush_mul.in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 12; k++) begin
      check("flush_mul.no_valid", {31'd0, bus.out_valid}, 32'd0);
      tick();
    end
`endif

    // Normal op after flush
    drive(ADD, 16'h0002, 16'h0003, 1'b0, 6'b000110);
    bus.in_valid = 1'b1;
    tick();
    check_out("after_flush", 16'h0005, 4'b0000, 6'b000110);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
